envelope_shaper: RTL and testbench

Per-voice ADSR amplitude envelope placed directly downstream of the wavetable player. It samples the player's 16-bit output once per audio sample period (every `MCLK_PER_SAMPLE` mclk), advances a gate-driven attack/decay/sustain/release state machine, scales the sample by the envelope level, and presents the shaped sample with a one-cycle valid strobe to the mixer/I2S path.

---
 rtl/synth_pkg.sv | 18 +
 rtl/sample_tick_gen.sv | 25 ++
 rtl/envelope_shaper.sv | 138 +++++++++++++
 tb/tb_envelope_shaper.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the per-voice synth datapath:
// envelope state encoding, level full-scale value and the signed sample type.
package synth_pkg;

   localparam int unsigned LEVEL_W = 16;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   typedef logic signed [15:0] sample_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ATTACK,
      ST_DECAY,
      ST_SUSTAIN,
      ST_RELEASE
   } env_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: emits a one-cycle tick on the last mclk of every
// DIV-cycle sample period. The first tick arrives DIV cycles after reset.
module sample_tick_gen #(
   parameter int DIV = 256
) (
   input  logic mclk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] count_q;

   assign tick = (count_q == CW'(DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n)    count_q <= '0;
      else if (tick) count_q <= '0;
      else           count_q <= count_q + CW'(1);
   end

endmodule

// File: rtl/envelope_shaper.sv
// Per-voice ADSR amplitude envelope: gate-driven state machine updated once per
// sample tick, sample x level multiply, two-stage output pipeline.
// Optional exponential release: define ENVELOPE_EXP_RELEASE_EN.
module envelope_shaper
   import synth_pkg::*;
#(
   parameter int MCLK_PER_SAMPLE = 256,
   parameter int LEVEL_BITS      = LEVEL_W
) (
   input  logic                  mclk,
   input  logic                  rst_n,
   input  logic                  gate,
   input  logic [LEVEL_BITS-1:0] attack_rate,
   input  logic [LEVEL_BITS-1:0] decay_rate,
   input  logic [LEVEL_BITS-1:0] sustain_level,
   input  logic [LEVEL_BITS-1:0] release_rate,
   input  sample_t               in_sample,
   input  logic                  in_valid,
   output sample_t               out_sample,
   output logic                  out_valid,
   output logic                  env_active
);

   typedef logic [LEVEL_BITS:0]                 wide_t;
   typedef logic signed [LEVEL_BITS+16:0]       product_t;

   localparam wide_t LMAX_W = {1'b0, {LEVEL_BITS{1'b1}}};

   logic                  tick;
   env_state_t            state_q, state_d;
   logic [LEVEL_BITS-1:0] level_q, level_d;
   sample_t               sample_q;
   product_t              product_q;
   logic                  p1_q, p2_q;

   wide_t level_w, attack_sum, decay_floor, rel_step;

   sample_tick_gen #(.DIV(MCLK_PER_SAMPLE)) u_tick (
      .mclk  (mclk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign level_w     = {1'b0, level_q};
   assign attack_sum  = level_w + {1'b0, attack_rate};
   assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_rate};

`ifdef ENVELOPE_EXP_RELEASE_EN
   logic [3:0] rel_shift;
   assign rel_shift = (release_rate[3:0] == 4'd0) ? 4'd1 : release_rate[3:0];
   assign rel_step  = (level_w >> rel_shift) + wide_t'(1);
`else
   assign rel_step  = {1'b0, release_rate};
`endif

   // NOTE: defaults first so every path assigns state_d/level_d -- no latches.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      unique case (state_q)
         ST_IDLE: begin
            level_d = '0;
            if (gate) state_d = ST_ATTACK;
         end
         ST_ATTACK: begin
            if (!gate) state_d = ST_RELEASE;
            else if (attack_rate != '0) begin
               if (attack_sum >= LMAX_W) begin
                  level_d = LMAX_W[LEVEL_BITS-1:0];
                  state_d = ST_DECAY;
               end else begin
                  level_d = attack_sum[LEVEL_BITS-1:0];
               end
            end
         end
         ST_DECAY: begin
            if (!gate) state_d = ST_RELEASE;
            else if (decay_rate != '0) begin
               // Also covers a sustain target above the level on entry.
               if (level_w <= decay_floor) begin
                  level_d = sustain_level;
                  state_d = ST_SUSTAIN;
               end else begin
                  level_d = level_q - decay_rate;
               end
            end
         end
         ST_SUSTAIN: begin
            if (!gate) state_d = ST_RELEASE;
            else       level_d = sustain_level;
         end
         ST_RELEASE: begin
            if (gate) state_d = ST_ATTACK;
            else if (rel_step != '0) begin
               if (level_w <= rel_step) begin
                  level_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  level_d = level_q - rel_step[LEVEL_BITS-1:0];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         level_q  <= '0;
         sample_q <= '0;
      end else if (tick) begin
         state_q <= state_d;
         level_q <= level_d;
         if (in_valid) sample_q <= in_sample;
      end
   end

   // Tick -> product (T+1) -> output (T+2).
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         p1_q       <= 1'b0;
         p2_q       <= 1'b0;
         product_q  <= '0;
         out_sample <= '0;
         out_valid  <= 1'b0;
      end else begin
         p1_q      <= tick;
         p2_q      <= p1_q;
         out_valid <= p2_q;
         if (p1_q) product_q  <= product_t'(sample_q) * product_t'($signed({1'b0, level_q}));
         if (p2_q) out_sample <= sample_t'(product_q >>> LEVEL_BITS);
      end
   end

   assign env_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_envelope_shaper.sv
// Directed table-driven bench for envelope_shaper: one table row per sample
// tick, plus hand sequences for reset, pulse spacing and exponential release.
module tb_envelope_shaper;
   import synth_pkg::*;

   localparam int N = 256;

   logic        mclk = 1'b0;
   logic        rst_n;
   logic        gate;
   logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
   sample_t     in_sample;
   logic        in_valid;
   sample_t     out_sample;
   logic        out_valid;
   logic        env_active;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        gate;
      logic [15:0] atk, dec, sus, rel;
      sample_t     smp;
      logic        vld;
      sample_t     exp_out;
      logic        exp_act;
   } vec_t;

   vec_t vecs[$];

   envelope_shaper #(.MCLK_PER_SAMPLE(N), .LEVEL_BITS(16)) dut (
      .mclk          (mclk),
      .rst_n         (rst_n),
      .gate          (gate),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .in_sample     (in_sample),
      .in_valid      (in_valid),
      .out_sample    (out_sample),
      .out_valid     (out_valid),
      .env_active    (env_active)
   );

   always #5 mclk = ~mclk;

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic add(input logic g, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] s, input logic [15:0] r, input sample_t smp,
                      input logic v, input sample_t eo, input logic ea);
      vec_t t;
      t.gate = g; t.atk = a; t.dec = d; t.sus = s; t.rel = r;
      t.smp = smp; t.vld = v; t.exp_out = eo; t.exp_act = ea;
      vecs.push_back(t);
   endtask

   // Waits for the next out_valid pulse, sampling on falling edges.
   task automatic wait_pulse(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 600 && !ok; n++) begin
         @(negedge mclk);
         if (out_valid) ok = 1'b1;
      end
   endtask

   task automatic apply(input vec_t v);
      gate = v.gate; attack_rate = v.atk; decay_rate = v.dec;
      sustain_level = v.sus; release_rate = v.rel;
      in_sample = v.smp; in_valid = v.vld;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bit ok;
      apply(v);
      wait_pulse(ok);
      check($sformatf("vec%0d_pulse", idx), int'(ok), 1);
      check($sformatf("vec%0d_out", idx), int'(out_sample), int'(v.exp_out));
      check($sformatf("vec%0d_active", idx), int'(env_active), int'(v.exp_act));
   endtask

   initial begin
      bit ok;
      int edges;
      int pulses;

`ifndef ENVELOPE_EXP_RELEASE_EN
      //   gate atk     dec   sus    rel    in      vld out     act
      add(0, 16384,  8192, 32768,  4096,   1000, 1,      0, 0);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,      0, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,   4096, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,   8192, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,  12288, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,  16383, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,  14335, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,  12287, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,  10239, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,   8192, 1);
      add(1, 16384,  8192, 32768,  4096,  16384, 1,   8192, 1);
      add(1, 16384,  8192, 16384,  4096,  16384, 1,   4096, 1);
      add(0, 16384,  8192, 16384,  4096,  16384, 1,   4096, 1);
      add(0, 16384,  8192, 16384,  4096,  16384, 1,   3072, 1);
      add(0, 16384,  8192, 16384,  4096,  16384, 1,   2048, 1);
      add(0, 16384,  8192, 16384,  4096,  16384, 1,   1024, 1);
      add(0, 16384,  8192, 16384,  4096,  16384, 1,      0, 0);
      add(0, 16384,  8192, 16384,  4096,  16384, 1,      0, 0);
      add(1,  8192,  8192, 16384,  4096,  16384, 1,      0, 1);
      add(1,  8192,  8192, 16384,  4096,  16384, 1,   2048, 1);
      add(0,  8192,  8192, 16384,  4096,  16384, 1,   2048, 1);
      add(1,  8192,  8192, 16384,  4096,  16384, 1,   2048, 1);
      add(1,  8192,  8192, 16384,  4096,  16384, 1,   4096, 1);
      add(1, LEVEL_MAX,   0, 16384,  4096, -32768, 1, -32768, 1);
      add(1, LEVEL_MAX,   0, 16384,  4096,      5, 0, -32768, 1);
      add(1, LEVEL_MAX,   0, 16384,  4096,  16384, 1,  16383, 1);
      add(1, LEVEL_MAX,   0, 16384,  4096,    100, 0,  16383, 1);
      add(0, LEVEL_MAX,   0, 16384, 65535,    100, 0,  16383, 1);
      add(0, LEVEL_MAX,   0, 16384, 65535,    100, 0,      0, 0);
`else
      add(1, LEVEL_MAX,   0,     0,     1,  16384, 1,      0, 1);
      add(1, LEVEL_MAX,   0,     0,     1,  16384, 1,  16383, 1);
      add(1, LEVEL_MAX,   0,     0,     1,  16384, 1,  16383, 1);
      add(0, LEVEL_MAX,   0,     0,     1,  16384, 1,  16383, 1);
      add(0, LEVEL_MAX,   0,     0,     1,  16384, 1,   8191, 1);
      add(0, LEVEL_MAX,   0,     0,     1,  16384, 1,   4095, 1);
`endif

      rst_n = 1'b0;
      apply(vecs[0]);
      repeat (5) @(negedge mclk);
      check("reset_out_sample", int'(out_sample), 0);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_env_active", int'(env_active), 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

`ifdef ENVELOPE_EXP_RELEASE_EN
      // Exponential release must still reach zero in a bounded number of ticks.
      for (int i = 0; i < 20 && env_active; i++) wait_pulse(ok);
      check("exp_release_reaches_idle", int'(env_active), 0);
      check("exp_release_out_zero", int'(out_sample), 0);
`endif

      // Exactly one out_valid cycle per sample period.
      pulses = 0;
      repeat (4 * N) begin
         @(negedge mclk);
         if (out_valid) pulses++;
      end
      check("valid_pulses_per_1024", pulses, 4);

      // Reset mid-release: start a note, release it slowly, then pulse rst_n.
      gate = 1'b1; attack_rate = 16'hFFFF; decay_rate = 16'd0;
      sustain_level = 16'd0; release_rate = 16'd1;
      in_sample = 16384; in_valid = 1'b1;
      wait_pulse(ok);
      wait_pulse(ok);
      gate = 1'b0;
      wait_pulse(ok);
      wait_pulse(ok);
      check("pre_reset_active", int'(env_active), 1);
      check("pre_reset_out_nonzero", int'(out_sample != 0), 1);
      repeat (37) @(negedge mclk);
      rst_n = 1'b0;
      #1;
      check("midreset_out_sample", int'(out_sample), 0);
      check("midreset_out_valid", int'(out_valid), 0);
      check("midreset_env_active", int'(env_active), 0);
      repeat (3) @(negedge mclk);
      rst_n = 1'b1;

      // First tick lands N cycles after release; out_valid follows 2 cycles later.
      edges = 0;
      ok = 1'b0;
      while (!ok && edges < 600) begin
         @(negedge mclk);
         edges++;
         if (out_valid) ok = 1'b1;
      end
      check("post_reset_first_valid_cycle", edges, N + 2);
      check("post_reset_out_sample", int'(out_sample), 0);
      check("post_reset_env_active", int'(env_active), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
